// File: rtl/filter_capture.sv
// Captures 256 consecutive filter samples and tracks peak |sample|, then streams them out in index order.
// First word appears 2 cycles into readout; outReady stalls hold the output, and a skid slot keeps a word per cycle flowing.
module filter_capture #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  output logic             outLast,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] peak
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [WIDTH-1:0]  MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_end_q, rd_end_d;
  logic                pend_q, pend_d;
  logic                pend_last_q, pend_last_d;
  logic                skid_vld_q, skid_vld_d;
  logic                skid_last_q, skid_last_d;
  logic [WIDTH-1:0]    skid_dat_q, skid_dat_d;
  logic                out_vld_q, out_vld_d;
  logic                out_last_q, out_last_d;
  logic [WIDTH-1:0]    out_dat_q, out_dat_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    peak_q, peak_d;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    ram_dat_q;

  logic [WIDTH-1:0]    mag;
  logic [1:0]          occ;
  logic                xfer;
  logic                out_free;
  logic                rd_issue;

  always_comb begin
    if (!in[WIDTH-1])        mag = in;
    else if (in == MOST_NEG) mag = MAX_POS;
    else                     mag = (~in) + WIDTH'(1);
  end

  // Words in the output reg, skid slot and RAM read stage never exceed two,
  // so a word returning from RAM always has somewhere to land.
  always_comb begin
    xfer     = out_vld_q & outReady;
    out_free = ~out_vld_q | outReady;
    occ      = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(pend_q);
    rd_issue = (state_q == READOUT) && !rd_end_q && ((occ - 2'(xfer)) < 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_end_d    = rd_end_q;
    peak_d      = peak_q;
    done_d      = 1'b0;
    pend_d      = rd_issue;
    pend_last_d = (rd_addr_q == LAST_ADDR);
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_dat_d  = skid_dat_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_dat_d   = out_dat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CAPTURE;
          wr_addr_d = '0;
          peak_d    = '0;
        end
      end
      CAPTURE: begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        if (mag > peak_q) peak_d = mag;
        if (wr_addr_q == LAST_ADDR) begin
          state_d   = READOUT;
          rd_addr_d = '0;
          rd_end_d  = 1'b0;
        end
      end
      READOUT: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (rd_addr_q == LAST_ADDR) rd_end_d = 1'b1;
        end
        if (xfer && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Oldest word first: output reg, then skid slot, then RAM read data.
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_dat_d   = skid_dat_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = pend_q;
        skid_dat_d  = ram_dat_q;
        skid_last_d = pend_last_q;
      end else if (pend_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = ram_dat_q;
        out_last_d = pend_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (pend_q) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = ram_dat_q;
      skid_last_d = pend_last_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rd_end_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_dat_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_dat_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      peak_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_end_q    <= rd_end_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_dat_q  <= skid_dat_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_dat_q   <= out_dat_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      peak_q      <= peak_d;
    end
  end

  // Sample buffer: contents survive reset, only the control state is cleared.
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) mem[wr_addr_q] <= in;
    if (rd_issue)           ram_dat_q      <= mem[rd_addr_q];
  end

  assign outData  = out_dat_q;
  assign outValid = out_vld_q;
  assign outLast  = out_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign peak     = peak_q;

endmodule
